// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding RISC-V load/store initiator to a word-wide, byte-enabled memory
module lsu_mem_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t          state_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [CW-1:0]   cnt_q;
    logic            legal_d;
    logic [3:0]      be_d;
    logic [DATA_WIDTH-1:0] wdata_d, lane_d, rdata_d;
    always_comb begin
        legal_d = req_we
            ? (req_funct3 == 3'b000 || (req_funct3 == 3'b001 && !req_addr[0]) ||
               (req_funct3 == 3'b010 && req_addr[1:0] == 2'b00))
            : (req_funct3 == 3'b000 || req_funct3 == 3'b100 ||
               ((req_funct3 == 3'b001 || req_funct3 == 3'b101) && !req_addr[0]) ||
               (req_funct3 == 3'b010 && req_addr[1:0] == 2'b00));
        be_d    = !req_we ? 4'hF
                : req_funct3 == 3'b000 ? 4'b0001 << req_addr[1:0]
                : req_funct3 == 3'b001 ? 4'b0011 << req_addr[1:0] : 4'hF;
        wdata_d = !req_we ? '0
                : req_funct3 == 3'b000 ? {4{req_wdata[7:0]}}
                : req_funct3 == 3'b001 ? {2{req_wdata[15:0]}} : req_wdata;
        lane_d  = mem_rdata >> {off_q, 3'b000};
        // funct3[2] selects zero-extension (lbu/lhu)
        rdata_d = f3_q[1:0] == 2'b00 ? {{24{lane_d[7] & ~f3_q[2]}}, lane_d[7:0]}
                : f3_q[1:0] == 2'b01 ? {{16{lane_d[15] & ~f3_q[2]}}, lane_d[15:0]} : lane_d;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            cnt_q      <= '0;
            f3_q       <= '0;
            off_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid && req_ready) begin
                    req_ready <= 1'b0;
                    f3_q      <= req_funct3;
                    off_q     <= req_addr[1:0];
                    cnt_q     <= '0;
                    if (legal_d) begin
                        state_q   <= BUS;
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_be    <= be_d;
                        mem_wdata <= wdata_d;
                    end else begin
                        state_q    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                BUS: begin
                    cnt_q <= cnt_q + 1'b1;
                    // ack takes priority over a timeout reached in the same cycle
                    if (mem_ack) begin
                        state_q    <= RESP;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= mem_we ? '0 : rdata_d;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q    <= RESP;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the RISC-V core and a word-organised, byte-enabled data memory.
- Accepts one load/store request at a time, keyed by funct3 (lb/lh/lw/lbu/lhu, sb/sh/sw).
- Drives a word-aligned memory transaction with byte-lane-shifted write data and byte enables, then extracts and sign/zero-extends load data.
- Flags misaligned accesses, illegal funct3 values and memory timeouts as errors instead of issuing or finishing the access.

Parameters:
- DATA_WIDTH, 32, data word width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  core request valid.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V load/store funct3.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_WIDTH  extended load result; 0 for stores and errors.
- resp_err  output  1  qualified by resp_valid; misaligned, illegal funct3 or timeout.
- mem_req  output  1  memory transaction request; held until ack or timeout.
- mem_we  output  1  write strobe.
- mem_addr  output  ADDR_WIDTH  word-aligned address, with bits [1:0] = 0.
- mem_be  output  4  byte enables; bit i = byte lane i.
- mem_wdata  output  DATA_WIDTH  lane-shifted store data.
- mem_ack  input  1  memory completes the transaction this cycle.
- mem_rdata  input  DATA_WIDTH  full read word; valid when mem_ack is high.

Behaviour:
- Reset values (synchronous): state = IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_be = 0, mem_wdata = 0, timeout counter = 0.
- A reset asserted mid-transaction aborts it. No response is produced, and mem_req is low after that edge.
- All outputs are registered.
- States are IDLE, BUS, RESP.
- IDLE → BUS (legal request):
  - Trigger: req_valid and req_ready are both high at edge T and the request is legal.
  - The block latches we, funct3 and addr[1:0].
  - From T+1 it drives mem_req = 1, mem_we = req_we, and mem_addr = req_addr with bits [1:0] cleared.
  - For loads mem_be = 1111.
  - For stores, with off = addr[1:0]:
    - sb: be = 0001 << off; wdata = byte replicated in all 4 lanes.
    - sh: be = 0011 << off; wdata = halfword replicated in both halves.
    - sw: be = 1111; wdata = req_wdata.
- IDLE → RESP (illegal request): no memory transaction is issued. resp_valid = 1 and resp_err = 1 at T+1.
- An illegal request is any of:
  - load funct3 of 011, 110 or 111;
  - store funct3 above 010;
  - lh/lhu/sh with addr[0] = 1;
  - lw/sw with addr[1:0] not equal to 00.
- BUS:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata stay stable until the ack edge.
  - If mem_ack = 1 at edge A: mem_req = 0 from A+1 and the state moves to RESP.
  - In the same edge, loads capture the result. Lane select is mem_rdata >> (8 × off).
    - lb: sign-extend bits [7:0].
    - lbu: zero-extend bits [7:0].
    - lh: sign-extend bits [15:0].
    - lhu: zero-extend bits [15:0].
    - lw: full word.
  - Result: resp_valid = 1 at A+1 with resp_err = 0. Load-to-response latency is therefore 1 cycle after ack.
  - The counter increments each BUS cycle without ack. When it reaches TIMEOUT, mem_req drops and the state moves to RESP with resp_err = 1.
  - With TIMEOUT = 255, mem_req is high for exactly 255 cycles.
- RESP: resp_valid is high for exactly one cycle, then the state returns to IDLE. req_ready = 1 on the following cycle, so back-to-back accesses take at least 3 cycles each.
- mem_ack outside BUS is ignored.
- A mem_ack arriving in the same cycle the timeout count is reached counts as success; ack wins.
- req_valid while req_ready = 0 is not accepted. The requester must hold it.

Test Plan:
- sb: req_addr = 0x0000_1003, req_wdata = 0x1234_56AB, ack after 2 cycles → mem_addr = 0x0000_1000, mem_be = 1000, mem_wdata[31:24] = 0xAB, resp_valid pulses 1 cycle after ack with resp_err = 0.
- lb / lbu: addr = 0x11, mem_rdata = 0x0000_8000 → lb gives resp_rdata = 0xFFFF_FF80; lbu gives 0x0000_0080.
- lh / lhu: addr = 0x22, mem_rdata = 0x9ABC_0000 → lh gives 0xFFFF_9ABC; lhu gives 0x0000_9ABC.
- Illegal requests: lw at addr 0x06, sh at addr 0x01, load funct3 = 011 → mem_req never asserts, resp_valid and resp_err are high 1 cycle after acceptance, resp_rdata = 0.
- Timeout: lw with mem_ack held low → mem_req high for TIMEOUT cycles, then resp_err = 1. A following request is accepted normally and acked at cycle 1.
- Reset mid-BUS: assert reset while mem_req = 1 → next cycle all outputs are at reset values, no resp_valid pulse, and a late mem_ack is ignored.
